// File: rtl/ysyx_22050550_trap_ctrl_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
//   XLEN / MTIP_BIT : data width and timer-interrupt bit position in mip/mie
//   CSR_*           : bit positions inside the wbcsren write-enable vector
//   MS_*            : mstatus field positions
//   CAUSE_*         : mcause values written on trap entry
//   state_e/event_e : sequencer states and the event kind latched at accept
package ysyx_22050550_trap_ctrl_pkg;

  localparam int unsigned XLEN     = 64;
  localparam int unsigned MTIP_BIT = 7;
  localparam int unsigned CSREN_W  = 8;

  localparam int unsigned CSR_MEPC    = 0;
  localparam int unsigned CSR_MCAUSE  = 1;
  localparam int unsigned CSR_MTVEC   = 2;
  localparam int unsigned CSR_MSTATUS = 3;
  localparam int unsigned CSR_MIE     = 4;
  localparam int unsigned CSR_MIP     = 5;

  localparam int unsigned MS_MIE    = 3;
  localparam int unsigned MS_MPIE   = 7;
  localparam int unsigned MS_MPP_LO = 11;
  localparam int unsigned MS_MPP_HI = 12;

  localparam logic [XLEN-1:0] CAUSE_ECALL_M    = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT = XLEN'(3);
  localparam logic [XLEN-1:0] CAUSE_MTI        = {1'b1, (XLEN-1)'(7)};

  // Vectored-mode offset for the machine timer interrupt (4 * cause code 7)
  localparam logic [XLEN-1:0] VEC_MTI_OFF = XLEN'(28);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WRCSR    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_IRQ    = 3'd1,
    EV_ECALL  = 3'd2,
    EV_EBREAK = 3'd3,
    EV_MRET   = 3'd4
  } event_e;

  // Trap vector base with the mode bits cleared
  function automatic logic [XLEN-1:0] mtvec_base(input logic [XLEN-1:0] mtvec);
    return {mtvec[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22050550_trap_ctrl_if.sv
// Bus bundle between the trap sequencer and its neighbours.
//   commit_*   : retiring-instruction info from writeback (commit_ready back)
//   csr inputs : mepc, mtvec, mstatus, mie, mip current values
//   wb*        : CSR write data and per-CSR enables into the register file
//   flush / redirect_* : kill + PC redirect handshake to fetch
// master = the sequencer, slave = the surrounding pipeline/register file.
interface ysyx_22050550_trap_ctrl_if;
  import ysyx_22050550_trap_ctrl_pkg::*;

  logic               commit_valid;
  logic               commit_ready;
  logic [XLEN-1:0]    commit_pc;
  logic [XLEN-1:0]    commit_npc;
  logic               commit_ecall;
  logic               commit_ebreak;
  logic               commit_mret;
  logic               timer_irq;
  logic [XLEN-1:0]    mepc;
  logic [XLEN-1:0]    mtvec;
  logic [XLEN-1:0]    mstatus;
  logic [XLEN-1:0]    mie;
  logic [XLEN-1:0]    mip;
  logic [XLEN-1:0]    wbmepc;
  logic [XLEN-1:0]    wbmcause;
  logic [XLEN-1:0]    wbmstatus;
  logic [XLEN-1:0]    wbmip;
  logic [CSREN_W-1:0] wbcsren;
  logic               flush;
  logic               redirect_valid;
  logic               redirect_ready;
  logic [XLEN-1:0]    redirect_pc;

  modport master (
    input  commit_valid, commit_pc, commit_npc, commit_ecall, commit_ebreak,
           commit_mret, timer_irq, mepc, mtvec, mstatus, mie, mip, redirect_ready,
    output commit_ready, wbmepc, wbmcause, wbmstatus, wbmip, wbcsren, flush,
           redirect_valid, redirect_pc
  );

  modport slave (
    output commit_valid, commit_pc, commit_npc, commit_ecall, commit_ebreak,
           commit_mret, timer_irq, mepc, mtvec, mstatus, mie, mip, redirect_ready,
    input  commit_ready, wbmepc, wbmcause, wbmstatus, wbmip, wbcsren, flush,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/ysyx_22050550_trap_ctrl_mstatus_upd.sv
// Combinational mstatus images for trap entry and mret.
//   i_mstatus      : current mstatus
//   o_trap_mstatus : MPIE<=MIE, MIE<=0, MPP<=M
//   o_mret_mstatus : MIE<=MPIE, MPIE<=1, MPP<=M
module ysyx_22050550_mstatus_upd
  import ysyx_22050550_trap_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] i_mstatus,
  output logic [XLEN-1:0] o_trap_mstatus,
  output logic [XLEN-1:0] o_mret_mstatus
);

  always_comb begin
    o_trap_mstatus                      = i_mstatus;
    o_trap_mstatus[MS_MPIE]             = i_mstatus[MS_MIE];
    o_trap_mstatus[MS_MIE]              = 1'b0;
    o_trap_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;

    o_mret_mstatus                      = i_mstatus;
    o_mret_mstatus[MS_MIE]              = i_mstatus[MS_MPIE];
    o_mret_mstatus[MS_MPIE]             = 1'b1;
    o_mret_mstatus[MS_MPP_HI:MS_MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/ysyx_22050550_trap_ctrl.sv
// Machine-mode trap sequencer: IDLE -> WRCSR (CSR write pulse) -> REDIRECT
// (hold redirect until fetch accepts). Independently mirrors timer_irq into
// mip with a one-cycle write pulse whenever the two disagree.
//   clock, reset : clock and asynchronous active-low reset
//   bus          : commit / CSR / write-back / redirect bundle (master side)
module ysyx_22050550_trap_ctrl
  import ysyx_22050550_trap_ctrl_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  ysyx_22050550_trap_ctrl_if.master   bus
);

  state_e             r_state;
  event_e             r_kind;
  logic [XLEN-1:0]    r_wbmepc;
  logic [XLEN-1:0]    r_wbmcause;
  logic [XLEN-1:0]    r_wbmstatus;
  logic [XLEN-1:0]    r_wbmip;
  logic [CSREN_W-1:0] r_wbcsren;
  logic               r_flush;
  logic               r_redirect_valid;
  logic [XLEN-1:0]    r_redirect_pc;

  logic               w_idle;
  logic               w_irq;
  event_e             w_event;
  logic [XLEN-1:0]    w_cause;
  logic [XLEN-1:0]    w_target;
  logic [XLEN-1:0]    w_mip_img;
  logic [XLEN-1:0]    w_trap_ms;
  logic [XLEN-1:0]    w_mret_ms;
  logic               w_unused;

  ysyx_22050550_mstatus_upd u_mstatus_upd (
    .i_mstatus      (bus.mstatus),
    .o_trap_mstatus (w_trap_ms),
    .o_mret_mstatus (w_mret_ms)
  );

  assign w_idle   = (r_state == ST_IDLE);
  assign w_irq    = bus.mstatus[MS_MIE] & bus.mie[MTIP_BIT] & bus.mip[MTIP_BIT];
  // Only the MTIE bit of mie matters here
  assign w_unused = ^bus.mie;

  // Event priority at accept: irq > ecall > ebreak > mret
  always_comb begin
    w_event = EV_NONE;
    if (w_irq)                  w_event = EV_IRQ;
    else if (bus.commit_ecall)  w_event = EV_ECALL;
    else if (bus.commit_ebreak) w_event = EV_EBREAK;
    else if (bus.commit_mret)   w_event = EV_MRET;
  end

  always_comb begin
    w_cause = CAUSE_BREAKPOINT;
    case (w_event)
      EV_IRQ:   w_cause = CAUSE_MTI;
      EV_ECALL: w_cause = CAUSE_ECALL_M;
      default:  w_cause = CAUSE_BREAKPOINT;
    endcase
  end

  // Redirect target, evaluated in WRCSR from the latched event kind
  always_comb begin
    w_target = mtvec_base(bus.mtvec);
    if (r_kind == EV_MRET)
      w_target = bus.mepc;
    else if (r_kind == EV_IRQ && bus.mtvec[1:0] == 2'b01)
      w_target = mtvec_base(bus.mtvec) + VEC_MTI_OFF;
  end

  always_comb begin
    w_mip_img           = bus.mip;
    w_mip_img[MTIP_BIT] = bus.timer_irq;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state          <= ST_IDLE;
      r_kind           <= EV_NONE;
      r_wbmepc         <= '0;
      r_wbmcause       <= '0;
      r_wbmstatus      <= '0;
      r_wbmip          <= '0;
      r_wbcsren        <= '0;
      r_flush          <= 1'b0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      // Enables are pulses; the mip pulse skips a cycle so the register
      // file's write lands before the mismatch is looked at again
      r_wbcsren <= '0;
      if ((bus.timer_irq != bus.mip[MTIP_BIT]) && !r_wbcsren[CSR_MIP]) begin
        r_wbcsren[CSR_MIP] <= 1'b1;
        r_wbmip            <= w_mip_img;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.commit_valid && w_event != EV_NONE) begin
            r_kind                 <= w_event;
            r_flush                <= 1'b1;
            r_state                <= ST_WRCSR;
            r_wbcsren[CSR_MSTATUS] <= 1'b1;
            if (w_event == EV_MRET) begin
              r_wbmstatus <= w_mret_ms;
            end else begin
              r_wbcsren[CSR_MEPC]   <= 1'b1;
              r_wbcsren[CSR_MCAUSE] <= 1'b1;
              r_wbmstatus           <= w_trap_ms;
              r_wbmcause            <= w_cause;
              // An interrupt lets the retiring instruction complete
              r_wbmepc <= (w_event == EV_IRQ) ? bus.commit_npc : bus.commit_pc;
            end
          end
        end
        ST_WRCSR: begin
          r_redirect_valid <= 1'b1;
          r_redirect_pc    <= w_target;
          r_state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (bus.redirect_ready) begin
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_state          <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.commit_ready   = w_idle;
  assign bus.wbmepc         = r_wbmepc;
  assign bus.wbmcause       = r_wbmcause;
  assign bus.wbmstatus      = r_wbmstatus;
  assign bus.wbmip          = r_wbmip;
  assign bus.wbcsren        = r_wbcsren;
  assign bus.flush          = r_flush;
  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;

endmodule

// File: tb/tb_ysyx_22050550_trap_ctrl.sv
// Directed bench for the trap sequencer. A transaction-timeline model
// (accept -> CSR cycle -> redirect until ready) is checked every cycle,
// and literal expectations pin the worked examples.
module tb_ysyx_22050550_trap_ctrl;

  logic clock;
  logic reset;
  int   n_total;
  int   n_bad;

  ysyx_22050550_trap_ctrl_if bus ();

  ysyx_22050550_trap_ctrl dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register-file stand-in for mip: takes the DUT's mip write
  logic [63:0] mip_reg;
  assign bus.mip = mip_reg;

  // ---------------- model ----------------
  logic        m_active;
  int          m_age;
  logic        m_mret;
  logic [63:0] m_epc, m_cause, m_ms, m_target;
  logic        e_mip_en;
  logic [63:0] e_mip_data;

  function automatic logic irq_now();
    return bus.mstatus[3] & bus.mie[7] & mip_reg[7];
  endfunction

  function automatic logic [63:0] ms_trap(input logic [63:0] ms);
    return (ms & ~64'h88) | ({63'b0, ms[3]} << 7) | 64'h1800;
  endfunction

  function automatic logic [63:0] ms_mret(input logic [63:0] ms);
    return (ms & ~64'h88) | ({63'b0, ms[7]} << 3) | 64'h80 | 64'h1800;
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active   <= 1'b0;
      m_age      <= 0;
      e_mip_en   <= 1'b0;
      e_mip_data <= 64'h0;
      mip_reg    <= 64'h0;
    end else begin
      e_mip_en <= (bus.timer_irq != mip_reg[7]) && !e_mip_en;
      if ((bus.timer_irq != mip_reg[7]) && !e_mip_en)
        e_mip_data <= (mip_reg & ~64'h80) | ({63'b0, bus.timer_irq} << 7);
      if (bus.wbcsren[5]) mip_reg <= bus.wbmip;

      if (m_active) begin
        if (m_age == 1) m_age <= 2;
        else if (bus.redirect_ready) m_active <= 1'b0;
      end else if (bus.commit_valid && (irq_now() || bus.commit_ecall ||
                                        bus.commit_ebreak || bus.commit_mret)) begin
        m_active <= 1'b1;
        m_age    <= 1;
        if (irq_now()) begin
          m_mret   <= 1'b0;
          m_cause  <= 64'h8000_0000_0000_0007;
          m_epc    <= bus.commit_npc;
          m_ms     <= ms_trap(bus.mstatus);
          m_target <= (bus.mtvec & ~64'h3) + ((bus.mtvec[1:0] == 2'b01) ? 64'd28 : 64'd0);
        end else if (bus.commit_ecall || bus.commit_ebreak) begin
          m_mret   <= 1'b0;
          m_cause  <= bus.commit_ecall ? 64'd11 : 64'd3;
          m_epc    <= bus.commit_pc;
          m_ms     <= ms_trap(bus.mstatus);
          m_target <= bus.mtvec & ~64'h3;
        end else begin
          m_mret   <= 1'b1;
          m_ms     <= ms_mret(bus.mstatus);
          m_target <= bus.mepc;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (reset) begin
      logic       t;
      logic [7:0] en;
      t  = m_active && (m_age == 1);
      en = {2'b00, e_mip_en, 1'b0, t, 1'b0, t && !m_mret, t && !m_mret};
      chk("m_ready", 64'(bus.commit_ready), 64'(!m_active));
      chk("m_csren", 64'(bus.wbcsren), 64'(en));
      chk("m_flush", 64'(bus.flush), 64'(m_active));
      chk("m_rvalid", 64'(bus.redirect_valid), 64'(m_active && m_age >= 2));
      if (m_active && m_age >= 2) chk("m_rpc", bus.redirect_pc, m_target);
      if (en[0]) chk("m_mepc", bus.wbmepc, m_epc);
      if (en[1]) chk("m_mcause", bus.wbmcause, m_cause);
      if (en[3]) chk("m_mstatus", bus.wbmstatus, m_ms);
      if (en[5]) chk("m_mip", bus.wbmip, e_mip_data);
    end
  end

  // ---------------- stimulus ----------------
  // Present a commit for one accept edge; returns at the negedge of cycle N+1
  task automatic commit(input logic [63:0] pc, input logic [63:0] npc,
                        input logic e, input logic b, input logic m);
    @(negedge clock);
    bus.commit_valid  = 1'b1;
    bus.commit_pc     = pc;
    bus.commit_npc    = npc;
    bus.commit_ecall  = e;
    bus.commit_ebreak = b;
    bus.commit_mret   = m;
    @(negedge clock);
    bus.commit_valid  = 1'b0;
    bus.commit_ecall  = 1'b0;
    bus.commit_ebreak = 1'b0;
    bus.commit_mret   = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    bus.commit_valid   = 1'b0;
    bus.commit_pc      = '0;
    bus.commit_npc     = '0;
    bus.commit_ecall   = 1'b0;
    bus.commit_ebreak  = 1'b0;
    bus.commit_mret    = 1'b0;
    bus.timer_irq      = 1'b0;
    bus.mepc           = '0;
    bus.mtvec          = '0;
    bus.mstatus        = '0;
    bus.mie            = '0;
    bus.redirect_ready = 1'b1;

    #2;
    chk("rst_ready", 64'(bus.commit_ready), 64'd1);
    chk("rst_csren", 64'(bus.wbcsren), 64'd0);
    chk("rst_rvalid", 64'(bus.redirect_valid), 64'd0);
    chk("rst_rpc", bus.redirect_pc, 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // ecall
    bus.mtvec   = 64'h8000_0100;
    bus.mstatus = 64'h8;
    commit(64'h8000_0040, 64'h8000_0044, 1'b1, 1'b0, 1'b0);
    chk("ecall_en", 64'(bus.wbcsren), 64'h0B);
    chk("ecall_mepc", bus.wbmepc, 64'h8000_0040);
    chk("ecall_cause", bus.wbmcause, 64'd11);
    chk("ecall_ms", bus.wbmstatus, 64'h1880);
    @(negedge clock);
    chk("ecall_rpc", bus.redirect_pc, 64'h8000_0100);
    chk("ecall_rv", 64'(bus.redirect_valid), 64'd1);
    @(negedge clock);
    chk("ecall_idle", 64'(bus.commit_ready), 64'd1);

    // ebreak
    commit(64'h8000_0060, 64'h8000_0064, 1'b0, 1'b1, 1'b0);
    chk("ebrk_cause", bus.wbmcause, 64'd3);
    repeat (2) @(negedge clock);

    // mret with redirect backpressure
    bus.mepc           = 64'h8000_0044;
    bus.mstatus        = 64'hA_0000_0080;
    bus.redirect_ready = 1'b0;
    commit(64'h8000_0070, 64'h8000_0074, 1'b0, 1'b0, 1'b1);
    chk("mret_en", 64'(bus.wbcsren), 64'h08);
    chk("mret_ms", bus.wbmstatus, 64'hA_0000_1888);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("bp_rpc", bus.redirect_pc, 64'h8000_0044);
      chk("bp_rv", 64'(bus.redirect_valid), 64'd1);
      chk("bp_flush", 64'(bus.flush), 64'd1);
      chk("bp_ready", 64'(bus.commit_ready), 64'd0);
    end
    bus.redirect_ready = 1'b1;
    @(negedge clock);
    chk("bp_done_ready", 64'(bus.commit_ready), 64'd1);
    chk("bp_done_rv", 64'(bus.redirect_valid), 64'd0);

    // timer interrupt, vectored; irq beats the ecall on the same commit
    bus.mstatus   = 64'h8;
    bus.mie       = 64'h80;
    bus.mtvec     = 64'h8000_0101;
    bus.timer_irq = 1'b1;
    @(negedge clock);
    chk("mip_pulse_en", 64'(bus.wbcsren), 64'h20);
    chk("mip_pulse_d", bus.wbmip, 64'h80);
    @(negedge clock);
    chk("mip_settled", 64'(bus.wbcsren), 64'h00);
    commit(64'h8000_0044, 64'h8000_0048, 1'b1, 1'b0, 1'b0);
    chk("irq_cause", bus.wbmcause, 64'h8000_0000_0000_0007);
    chk("irq_mepc", bus.wbmepc, 64'h8000_0048);
    @(negedge clock);
    chk("irq_rpc", bus.redirect_pc, 64'h8000_011C);
    bus.mstatus   = 64'h0;
    bus.mie       = 64'h0;
    bus.timer_irq = 1'b0;
    repeat (3) @(negedge clock);

    // plain commit: nothing happens
    bus.mtvec = 64'h8000_0100;
    commit(64'h8000_0080, 64'h8000_0084, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("plain_en", 64'(bus.wbcsren), 64'd0);
      chk("plain_flush", 64'(bus.flush), 64'd0);
      chk("plain_ready", 64'(bus.commit_ready), 64'd1);
      @(negedge clock);
    end

    // async reset while in REDIRECT
    bus.redirect_ready = 1'b0;
    commit(64'h8000_0050, 64'h8000_0054, 1'b0, 1'b1, 1'b0);
    @(negedge clock);
    chk("pre_rst_rv", 64'(bus.redirect_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst_rv", 64'(bus.redirect_valid), 64'd0);
    chk("arst_flush", 64'(bus.flush), 64'd0);
    chk("arst_rpc", bus.redirect_pc, 64'd0);
    chk("arst_en", 64'(bus.wbcsren), 64'd0);
    chk("arst_mepc", bus.wbmepc, 64'd0);
    chk("arst_ready", 64'(bus.commit_ready), 64'd1);
    @(negedge clock);
    reset = 1'b1;
    bus.redirect_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_rst_ready", 64'(bus.commit_ready), 64'd1);
    chk("post_rst_rv", 64'(bus.redirect_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
